// File: rtl/chunked_adder_sub.sv
// chunked_adder_sub: multi-cycle two's-complement adder/subtractor.
// Adds CHUNK bits per clock and keeps the inter-chunk carry in a register,
// so the combinational carry chain is only CHUNK bits long.
// Optional macro ADDER_SATURATE_EN: on signed overflow the result is clamped
// to the most positive/negative value instead of wrapping.
module chunked_adder_sub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             subtract,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state;
    state_t state_next;

    // Latched operands; op_b is already inverted for subtraction so RUN only adds.
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [IDX_W-1:0] idx;
    logic             carry;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_carry;
    logic             msb_carry_in;
    logic             ovf_next;
    logic             last_chunk;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] result_next;

`ifdef ADDER_SATURATE_EN
    // Clamp value selected by the sign of the overflowing operand.
    function automatic logic [WIDTH-1:0] saturate(input logic neg);
        logic signed [WIDTH-1:0] lim;
        lim = neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return lim;
    endfunction
`endif

    // One CHUNK-wide slice of the addition plus the MSB flags for the final slice.
    always_comb begin
        a_chunk    = op_a[idx*CHUNK +: CHUNK];
        b_chunk    = op_b[idx*CHUNK +: CHUNK];
        last_chunk = (idx == LAST_IDX);
        {chunk_carry, chunk_sum} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
        // Carry into the top bit of this slice, recovered from its sum bit.
        msb_carry_in = chunk_sum[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
        ovf_next     = msb_carry_in ^ chunk_carry;
        sum_next     = sum;
        sum_next[idx*CHUNK +: CHUNK] = chunk_sum;
`ifdef ADDER_SATURATE_EN
        result_next = ovf_next ? saturate(op_a[WIDTH-1]) : sum_next;
`else
        result_next = sum_next;
`endif
    end

    // Handshake outputs and next state.
    always_comb begin
        state_next   = state;
        start_ready  = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) state_next = RUN;
            end
            RUN: begin
                if (last_chunk) state_next = DONE;
            end
            DONE: begin
                result_valid = 1'b1;
                if (result_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Chunk index, carry, result and flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx      <= '0;
            carry    <= 1'b0;
            sum      <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        idx   <= '0;
                        carry <= subtract;
                    end
                end
                RUN: begin
                    carry <= chunk_carry;
                    if (last_chunk) begin
                        idx      <= '0;
                        sum      <= result_next;
                        carryout <= chunk_carry;
                        overflow <= ovf_next;
                        zero     <= (result_next == '0);
                    end else begin
                        idx <= idx + 1'b1;
                        sum <= sum_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand capture on acceptance; pure data, no reset needed.
    always_ff @(posedge clk) begin
        if (state == IDLE && start_valid) begin
            op_a <= a;
            op_b <= b ^ {WIDTH{subtract}};
        end
    end

endmodule

// File: tb/tb_chunked_adder_sub.sv
// Scoreboard bench for chunked_adder_sub: a driver pushes expected results
// from an arithmetic reference model, a monitor pops them on each result
// handshake. A second instance with CHUNK == WIDTH covers the 1-cycle case.
module tb_chunked_adder_sub;

    localparam int W  = 32;
    localparam int NC = 8;

    typedef struct {
        logic [W-1:0] sum;
        logic         co;
        logic         ov;
        logic         zr;
        longint       acc;
    } exp_t;

    logic clk;
    logic rst_n, sv, sr, sub, rv, rr, co, ov, zr;
    logic [W-1:0] a, b, sum;
    logic rst1_n, sv1, sr1, sub1, rv1, rr1, co1, ov1, zr1;
    logic [W-1:0] a1, b1, sum1;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    bit     bp_hold = 0;
    exp_t   sb[$];
    logic   prev_rv = 1'b0;
    longint rise = 0;

    chunked_adder_sub #(.WIDTH(W), .CHUNK(4)) u0 (
        .clk(clk), .reset_n(rst_n), .start_valid(sv), .start_ready(sr),
        .a(a), .b(b), .subtract(sub), .result_valid(rv), .result_ready(rr),
        .sum(sum), .carryout(co), .overflow(ov), .zero(zr)
    );

    chunked_adder_sub #(.WIDTH(W), .CHUNK(W)) u1 (
        .clk(clk), .reset_n(rst1_n), .start_valid(sv1), .start_ready(sr1),
        .a(a1), .b(b1), .subtract(sub1), .result_valid(rv1), .result_ready(rr1),
        .sum(sum1), .carryout(co1), .overflow(ov1), .zero(zr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: signed/unsigned integer arithmetic on 64-bit values.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t e;
        longint sx, sy, r;
        longint unsigned ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        r  = s ? sx - sy : sx + sy;
        e.sum = r[31:0];
        e.ov  = (r != longint'($signed(e.sum)));
        e.co  = s ? (ux >= uy) : ((ux + uy) > 64'h0000_0000_FFFF_FFFF);
`ifdef ADDER_SATURATE_EN
        if (e.ov) e.sum = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        e.zr  = (e.sum == '0);
        e.acc = 0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input bit push);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (!sr && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!sr) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: start_ready 0 expected 1");
            return;
        end
        a = x; b = y; sub = s; sv = 1'b1;
        e = model(x, y, s);
        e.acc = cyc + 1;
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        sv = 1'b0; a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || !sr) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || !sr) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending %0d expected 0", sb.size());
        end
    endtask

    task automatic u1_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (!sr1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("u1_ready", 64'(sr1), 64'd1);
        a1 = x; b1 = y; sub1 = s; sv1 = 1'b1;
        e = model(x, y, s);
        @(posedge clk);
        #1;
        sv1 = 1'b0; a1 = $urandom; b1 = $urandom;
        @(negedge clk);
        chk("u1_run_not_valid", 64'(rv1), 64'd0);
        @(negedge clk);
        chk("u1_valid_after_1", 64'(rv1), 64'd1);
        chk("u1_sum", 64'(sum1), 64'(e.sum));
        chk("u1_flags", 64'({co1, ov1, zr1}), 64'({e.co, e.ov, e.zr}));
    endtask

    // Result-ready driver: random backpressure unless held off.
    initial begin
        rr = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rr = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pop and compare on every result handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rv && !prev_rv) rise = cyc;
            prev_rv = rv;
            if (rv && rr) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: sum %h with empty scoreboard", sum);
                end else begin
                    e = sb.pop_front();
                    chk("sum", 64'(sum), 64'(e.sum));
                    chk("carryout", 64'(co), 64'(e.co));
                    chk("overflow", 64'(ov), 64'(e.ov));
                    chk("zero", 64'(zr), 64'(e.zr));
                    chk("latency", 64'(rise - e.acc), 64'(NC));
                end
            end
        end
    end

    // Stimulus.
    initial begin
        logic [W-1:0] corner [5];
        logic [W-1:0] x, y;
        logic [W+2:0] snap;
        int n;
        corner[0] = 32'h0000_0000; corner[1] = 32'h0000_0001; corner[2] = 32'h7FFF_FFFF;
        corner[3] = 32'h8000_0000; corner[4] = 32'hFFFF_FFFF;
        rst_n = 1'b0; rst1_n = 1'b0;
        sv = 1'b0; a = '0; b = '0; sub = 1'b0;
        sv1 = 1'b0; a1 = '0; b1 = '0; sub1 = 1'b0; rr1 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", 64'(rv), 64'd0);
        chk("reset_outputs", 64'({sum, co, ov, zr}), 64'd0);
        chk("u1_reset_outputs", 64'({rv1, sum1, co1, ov1, zr1}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; rst1_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 64'(sr), 64'd1);

        // Directed cases.
        issue(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1);
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        issue(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
        issue(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1);
        issue(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1);
        issue(32'h1357_9BDF, 32'h0000_0000, 1'b1, 1'b1);
        issue(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);

        // Random cases with a bias towards corner operands.
        for (int i = 0; i < 40; i++) begin
            x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            issue(x, y, 1'($urandom_range(0, 1)), 1'b1);
        end
        wait_idle();

        // Backpressure in DONE with noisy inputs.
        bp_hold = 1'b1;
        issue(32'h1234_5678, 32'h0000_1111, 1'b0, 1'b1);
        n = 0;
        while (!rv && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_reach_done", 64'(rv), 64'd1);
        snap = {sum, co, ov, zr};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            sv = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("bp_valid_held", 64'(rv), 64'd1);
            chk("bp_result_held", 64'({sum, co, ov, zr}), 64'(snap));
            chk("bp_not_ready", 64'(sr), 64'd0);
        end
        @(posedge clk);
        #1;
        sv = 1'b0;
        bp_hold = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rr && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("bp_release_idle", 64'({sr, rv}), 64'b10);
        issue(32'h0000_0100, 32'h0000_0200, 1'b0, 1'b1);
        wait_idle();

        // Reset after the third RUN chunk; the aborted op must never surface.
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrun_reset_valid", 64'(rv), 64'd0);
        chk("midrun_reset_outputs", 64'({sum, co, ov, zr}), 64'd0);
        chk("midrun_reset_ready", 64'(sr), 64'd1);
        issue(32'h0000_0002, 32'h0000_0002, 1'b0, 1'b1);
        wait_idle();

        // Single-chunk instance: 1-cycle RUN, reset during RUN.
        u1_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        u1_op(32'h0000_0003, 32'h0000_0005, 1'b1);
        @(negedge clk);
        a1 = 32'hFFFF_FFFF; b1 = 32'h0000_0001; sub1 = 1'b0; sv1 = 1'b1;
        @(posedge clk);
        #1;
        sv1 = 1'b0;
        @(negedge clk);
        rst1_n = 1'b0;
        @(posedge clk);
        #1;
        rst1_n = 1'b1;
        @(negedge clk);
        chk("u1_reset_run", 64'({rv1, sum1, co1, ov1, zr1}), 64'd0);
        chk("u1_reset_ready", 64'(sr1), 64'd1);
        u1_op(32'h0000_0002, 32'h0000_0002, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
